// File: rtl/instruction_encoder.sv
// Keypad-driven instruction word assembler: collects funct/immA/immB as hex digits and offers
// the packed word {1'b0, funct, immA, immB} with an auto-incrementing address over valid/ready.
module instruction_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [1:0]        key_cmd,
  input  logic [3:0]        key_digit,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [1:0]        field_sel,
  output logic              key_err
);

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

  localparam logic [1:0] CmdDigit = 2'b00;
  localparam logic [1:0] CmdEnter = 2'b01;
  localparam logic [1:0] CmdClear = 2'b10;

  typedef enum logic [1:0] {
    StFunct = 2'd0,
    StImmA  = 2'd1,
    StImmB  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct_q, funct_d;
  logic [13:0]       imma_q, imma_d;
  logic [13:0]       immb_q, immb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              key_err_q, key_err_d;

  always_comb begin
    state_d   = state_q;
    funct_d   = funct_q;
    imma_d    = imma_q;
    immb_d    = immb_q;
    addr_d    = addr_q;
    key_err_d = 1'b0;

    if (state_q == StDone) begin
      // Keys are ignored here so the offered word cannot change before it is accepted.
      if (instr_ready) begin
        funct_d = '0;
        imma_d  = '0;
        immb_d  = '0;
        addr_d  = addr_q + 1'b1;
        state_d = StFunct;
      end
    end else if (key_valid) begin
      unique case (key_cmd)
        CmdDigit: begin
          unique case (state_q)
            StFunct: begin
              if (key_digit <= 4'd7) funct_d = key_digit[2:0];
              else                   key_err_d = 1'b1;
            end
            StImmA:  imma_d = {imma_q[9:0], key_digit};
            StImmB:  immb_d = {immb_q[9:0], key_digit};
            default: ;
          endcase
        end
        CmdEnter: begin
          unique case (state_q)
            StFunct: state_d = StImmA;
            StImmA:  state_d = StImmB;
            StImmB:  state_d = StDone;
            default: ;
          endcase
        end
        CmdClear: begin
          funct_d = '0;
          imma_d  = '0;
          immb_d  = '0;
          state_d = StFunct;
        end
        default: key_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFunct;
      funct_q   <= '0;
      imma_q    <= '0;
      immb_q    <= '0;
      addr_q    <= StartAddr;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct_q   <= funct_d;
      imma_q    <= imma_d;
      immb_q    <= immb_d;
      addr_q    <= addr_d;
      key_err_q <= key_err_d;
    end
  end

  assign instr       = {1'b0, funct_q, imma_q, immb_q};
  assign instr_valid = (state_q == StDone);
  assign instr_addr  = addr_q;
  assign field_sel   = state_q;
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder (ADDR_W=2 to exercise address wrap).
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [1:0]  key_cmd;
  logic [3:0]  key_digit;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  instr_addr;
  logic [1:0]  field_sel;
  logic        key_err;

  instruction_encoder #(
    .ADDR_W    (2),
    .START_ADDR(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_cmd    (key_cmd),
    .key_digit  (key_digit),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_addr (instr_addr),
    .field_sel  (field_sel),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  // Reference model of the field registers and state
  logic [2:0]  m_funct;
  logic [13:0] m_imma;
  logic [13:0] m_immb;
  logic [1:0]  m_addr;
  logic [1:0]  m_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {1'b0, m_funct, m_imma, m_immb};
  endfunction

  task automatic model_clear();
    m_funct = '0;
    m_imma  = '0;
    m_immb  = '0;
  endtask

  task automatic key(input logic [1:0] cmd, input logic [3:0] d);
    logic exp_err;
    exp_err = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_cmd   = cmd;
    key_digit = d;
    if (m_sel != 2'd3) begin
      case (cmd)
        2'b00: begin
          if (m_sel == 2'd0) begin
            if (d <= 4'd7) m_funct = d[2:0];
            else           exp_err = 1'b1;
          end else if (m_sel == 2'd1) begin
            m_imma = {m_imma[9:0], d};
          end else begin
            m_immb = {m_immb[9:0], d};
          end
        end
        2'b01: begin
          if (m_sel == 2'd2) exp_q.push_back({m_addr, m_word()});
          m_sel = m_sel + 2'd1;
        end
        2'b10: begin
          model_clear();
          m_sel = 2'd0;
        end
        default: exp_err = 1'b1;
      endcase
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check("field_sel", 32'(field_sel), 32'(m_sel));
    check("instr", instr, m_word());
    check("key_err", 32'(key_err), 32'(exp_err));
    check("instr_valid", 32'(instr_valid), 32'(m_sel == 2'd3));
    check("instr_addr", 32'(instr_addr), 32'(m_addr));
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    check("key_err_drop", 32'(key_err), 32'd0);
  endtask

  task automatic accept();
    logic [33:0] e;
    @(negedge clk);
    instr_ready = 1'b1;
    check("valid_before_accept", 32'(instr_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'(exp_q.size()));
    end else begin
      e = exp_q.pop_front();
      check("sb_instr", instr, e[31:0]);
      check("sb_addr", 32'(instr_addr), 32'(e[33:32]));
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    if (m_sel == 2'd3) begin
      model_clear();
      m_addr = m_addr + 2'd1;
      m_sel  = 2'd0;
    end
    check("valid_after_accept", 32'(instr_valid), 32'd0);
    check("addr_after_accept", 32'(instr_addr), 32'(m_addr));
    check("instr_after_accept", instr, m_word());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    m_addr = 2'd0;
    m_sel  = 2'd0;
    exp_q.delete();
    check("rst_sel", 32'(field_sel), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", 32'(instr_addr), 32'd0);
    check("rst_err", 32'(key_err), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_cmd     = 2'b00;
    key_digit   = 4'h0;
    instr_ready = 1'b0;
    m_funct = '0; m_imma = '0; m_immb = '0; m_addr = '0; m_sel = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic word: funct 5, immA 0x1234, immB 0xABC
    key(2'b00, 4'h5); key(2'b01, 4'h0);
    key(2'b00, 4'h1); key(2'b00, 4'h2); key(2'b00, 4'h3); key(2'b00, 4'h4); key(2'b01, 4'h0);
    key(2'b00, 4'hA); key(2'b00, 4'hB); key(2'b00, 4'hC); key(2'b01, 4'h0);
    check("word_literal", instr, 32'h548D0ABC);
    accept();
    check("addr_one", 32'(instr_addr), 32'd1);

    // immA truncation, then rejected funct digit and reserved command
    key(2'b01, 4'h0);
    for (int i = 0; i < 5; i++) key(2'b00, 4'hF);
    check("imma_trunc", instr, 32'h0FFFC000);
    key(2'b10, 4'h0);
    key(2'b00, 4'h3);
    key(2'b00, 4'h9);
    idle_check();
    check("funct_kept", instr, 32'h30000000);
    key(2'b11, 4'h0);
    idle_check();

    // Backpressure: DONE ignores digits, clear, enter and reserved
    key(2'b01, 4'h0); key(2'b01, 4'h0); key(2'b00, 4'h7); key(2'b01, 4'h0);
    key(2'b00, 4'h1); key(2'b10, 4'h0); key(2'b00, 4'h9); key(2'b01, 4'h0); key(2'b11, 4'h0);
    check("bp_instr", instr, 32'h30000007);
    accept();

    // Three more empty words: address 2, 3, wraps to 0, ends at 1
    for (int w = 0; w < 3; w++) begin
      key(2'b01, 4'h0); key(2'b01, 4'h0); key(2'b01, 4'h0);
      check("empty_word", instr, 32'h00000000);
      accept();
    end
    check("wrap_addr", 32'(instr_addr), 32'd1);

    // Clear in IMMA keeps the address
    key(2'b00, 4'h2); key(2'b01, 4'h0); key(2'b00, 4'h5); key(2'b10, 4'h0);
    check("clear_addr", 32'(instr_addr), 32'd1);

    // Reset mid-entry in IMMB with immA 0x0123
    key(2'b01, 4'h0); key(2'b00, 4'h1); key(2'b00, 4'h2); key(2'b00, 4'h3);
    key(2'b01, 4'h0); key(2'b00, 4'h4);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
